// File: rtl/memory_stage.sv
// memory_stage: pipeline memory stage with IDLE/ACCESS handshake to data memory; MISALIGN_TRAP_EN enables misalignment trapping
module memory_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_ALU_result,
  input  logic [31:0] ex_store_data,
  input  logic        ex_MemRead,
  input  logic        ex_MemWrite,
  input  logic        ex_RegWrite,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_RegWrite,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        wb_misaligned
`endif
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t      state;
  logic        mem_op;
  logic [1:0]  lane;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [1:0]  acc_lane;
  logic [2:0]  acc_f3;
  logic [4:0]  acc_rd;
  logic        acc_rw;
  logic        acc_load;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_word;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned;
`endif
  assign ex_ready = state == IDLE;
  // lane selection, store strobes/data and load extraction (halves/words force their low address bits to 0)
  always_comb begin
    mem_op = ex_MemRead | ex_MemWrite;
    lane = ex_funct3[1] ? 2'b00 : ex_funct3[0] ? {ex_ALU_result[1], 1'b0} : ex_ALU_result[1:0];
    st_strb = ex_funct3[1] ? 4'b1111 : ex_funct3[0] ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b0001 << lane;
    st_data = ex_funct3[1] ? ex_store_data : ex_funct3[0] ? {2{ex_store_data[15:0]}} : {4{ex_store_data[7:0]}};
    ld_byte = dmem_rdata[{acc_lane, 3'b000} +: 8];
    ld_half = dmem_rdata[{acc_lane[1], 4'b0000} +: 16];
    ld_word = acc_f3[1] ? dmem_rdata :
              acc_f3[0] ? {{16{~acc_f3[2] & ld_half[15]}}, ld_half} :
                          {{24{~acc_f3[2] & ld_byte[7]}}, ld_byte};
`ifdef MISALIGN_TRAP_EN
    misaligned = ex_funct3[1] ? |ex_ALU_result[1:0] : ex_funct3[0] & ex_ALU_result[0];
`endif
  end
  // FSM: accept in IDLE, hold the memory request in ACCESS until ack, pulse writeback once per instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= '0;
      wb_valid <= 1'b0;
      wb_RegWrite <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
      acc_lane <= '0;
      acc_f3 <= '0;
      acc_rd <= '0;
      acc_rw <= 1'b0;
      acc_load <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      wb_misaligned <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
      if (state == IDLE) begin
        if (ex_valid) begin
          if (!mem_op) begin
            wb_valid <= 1'b1;
            wb_RegWrite <= ex_RegWrite;
            wb_rd <= ex_rd;
            wb_data <= ex_ALU_result;
`ifdef MISALIGN_TRAP_EN
            wb_misaligned <= 1'b0;
`endif
          end
`ifdef MISALIGN_TRAP_EN
          else if (misaligned) begin
            wb_valid <= 1'b1;
            wb_RegWrite <= 1'b0;
            wb_rd <= ex_rd;
            wb_data <= ex_ALU_result;
            wb_misaligned <= 1'b1;
          end
`endif
          else begin
            state <= ACCESS;
            dmem_req <= 1'b1;
            dmem_we <= ex_MemWrite;
            dmem_addr <= {ex_ALU_result[31:2], 2'b00};
            dmem_wdata <= st_data;
            dmem_wstrb <= ex_MemWrite ? st_strb : 4'b0000;
            acc_lane <= lane;
            acc_f3 <= ex_funct3;
            acc_rd <= ex_rd;
            acc_rw <= ex_RegWrite;
            acc_load <= ~ex_MemWrite;
          end
        end
      end else if (dmem_ack) begin
        state <= IDLE;
        dmem_req <= 1'b0;
        dmem_we <= 1'b0;
        dmem_wstrb <= 4'b0000;
        wb_valid <= 1'b1;
        wb_RegWrite <= acc_load & acc_rw;
        wb_rd <= acc_rd;
        if (acc_load) wb_data <= ld_word;
`ifdef MISALIGN_TRAP_EN
        wb_misaligned <= 1'b0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: randomized self-checking bench for memory_stage against a behavioural model
module tb_memory_stage;
  logic        clk = 0;
  logic        reset;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_ALU_result, ex_store_data;
  logic        ex_MemRead, ex_MemWrite, ex_RegWrite;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_RegWrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef MISALIGN_TRAP_EN
  logic        wb_misaligned;
`endif
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_data = 0;
  bit          known = 1;

  memory_stage dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_ALU_result(ex_ALU_result), .ex_store_data(ex_store_data),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_RegWrite(ex_RegWrite),
    .ex_funct3(ex_funct3), .ex_rd(ex_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data)
`ifdef MISALIGN_TRAP_EN
    , .wb_misaligned(wb_misaligned)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic scramble;
    ex_valid = 1'($urandom);
    ex_ALU_result = $urandom;
    ex_store_data = $urandom;
    ex_MemRead = 1'($urandom);
    ex_MemWrite = 1'($urandom);
    ex_RegWrite = 1'($urandom);
    ex_funct3 = 3'($urandom);
    ex_rd = 5'($urandom);
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return f3[1] ? 4 : f3[0] ? 2 : 1;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
    int sz;
    int off;
    logic [31:0] v;
    sz = size_of(f3);
    off = int'(addr % 4);
    off = off - off % sz;
    v = rdata >> (8 * off);
    if (sz == 1) begin
      v = v & 32'hff;
      if (!f3[2] && v >= 32'h80) v = v | 32'hffffff00;
    end else if (sz == 2) begin
      v = v & 32'hffff;
      if (!f3[2] && v >= 32'h8000) v = v | 32'hffff0000;
    end
    return v;
  endfunction

  task automatic do_op(input bit rdop, input bit wrop, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [4:0] rd, input bit rw, input int delay,
                       input logic [31:0] rdata);
    int sz, off;
    bit mem, ld, mis;
    logic [3:0] strb;
    logic [31:0] mask, exp_w;
    sz = size_of(f3);
    off = int'(addr % 4);
    mis = off % sz != 0;
    off = off - off % sz;
    mem = rdop | wrop;
    ld = rdop & !wrop;
    strb = 4'(((1 << sz) - 1) << off);
    mask = 0;
    for (int i = 0; i < 4; i++) if (strb[i]) mask = mask | (32'hff << (8 * i));
    exp_w = sz == 1 ? {4{sdata[7:0]}} : sz == 2 ? (sdata & 32'hffff) << (8 * off) : sdata;
    check("ready_idle", 32'(ex_ready), 1);
    ex_valid = 1; ex_MemRead = rdop; ex_MemWrite = wrop; ex_funct3 = f3;
    ex_ALU_result = addr; ex_store_data = sdata; ex_rd = rd; ex_RegWrite = rw;
    tick;
    ex_valid = 0;
    if (!mem) begin
      check("alu_valid", 32'(wb_valid), 1);
      check("alu_data", wb_data, addr);
      check("alu_rd", 32'(wb_rd), 32'(rd));
      check("alu_rw", 32'(wb_RegWrite), 32'(rw));
      check("alu_noreq", 32'(dmem_req), 0);
      exp_data = addr;
      known = 1;
    end
`ifdef MISALIGN_TRAP_EN
    else if (mis && sz > 1) begin
      check("trap_valid", 32'(wb_valid), 1);
      check("trap_flag", 32'(wb_misaligned), 1);
      check("trap_rw", 32'(wb_RegWrite), 0);
      check("trap_noreq", 32'(dmem_req), 0);
      known = 0;
    end
`endif
    else begin
      for (int i = 0; i <= delay; i++) begin
        check("req", 32'(dmem_req), 1);
        check("addr", dmem_addr, addr - addr % 4);
        check("we", 32'(dmem_we), 32'(wrop));
        check("busy", 32'(ex_ready), 0);
        check("no_wb", 32'(wb_valid), 0);
        if (wrop) begin
          check("wstrb", 32'(dmem_wstrb), 32'(strb));
          check("wdata", dmem_wdata & mask, exp_w & mask);
          if (sz == 1) check("wdata_rep", dmem_wdata, exp_w);
        end
        if (i == delay) begin
          dmem_ack = 1;
          dmem_rdata = rdata;
        end else begin
          scramble;
          dmem_ack = 0;
          dmem_rdata = $urandom;
        end
        tick;
      end
      ex_valid = 0;
      dmem_ack = 0;
      dmem_rdata = $urandom;
      check("mem_valid", 32'(wb_valid), 1);
      check("mem_rw", 32'(wb_RegWrite), 32'(ld & rw));
      check("mem_noreq", 32'(dmem_req), 0);
      check("mem_ready", 32'(ex_ready), 1);
`ifdef MISALIGN_TRAP_EN
      check("mem_noflag", 32'(wb_misaligned), 0);
`endif
      if (ld) begin
        check("ld_rd", 32'(wb_rd), 32'(rd));
        check("ld_data", wb_data, model_load(f3, addr, rdata));
        exp_data = model_load(f3, addr, rdata);
        known = 1;
      end
    end
    dmem_ack = 1'($urandom);
    tick;
    dmem_ack = 0;
    check("pulse_end", 32'(wb_valid), 0);
    if (known) check("wb_hold", wb_data, exp_data);
  endtask

  initial begin
    logic [2:0] f3s [5];
    int k;
    f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b010; f3s[3] = 3'b100; f3s[4] = 3'b101;
    reset = 1; ex_valid = 0; ex_ALU_result = 0; ex_store_data = 0; ex_MemRead = 0;
    ex_MemWrite = 0; ex_RegWrite = 0; ex_funct3 = 0; ex_rd = 0; dmem_ack = 0; dmem_rdata = 0;
    tick;
    tick;
    check("rst_valid", 32'(wb_valid), 0);
    check("rst_data", wb_data, 0);
    check("rst_rd", 32'(wb_rd), 0);
    check("rst_rw", 32'(wb_RegWrite), 0);
    check("rst_req", 32'(dmem_req), 0);
    check("rst_we", 32'(dmem_we), 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_wstrb", 32'(dmem_wstrb), 0);
    check("rst_ready", 32'(ex_ready), 1);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      dmem_ack = 1'($urandom);
      dmem_rdata = $urandom;
      ex_ALU_result = $urandom;
      tick;
      check("idle_valid", 32'(wb_valid), 0);
      check("idle_req", 32'(dmem_req), 0);
      check("idle_ready", 32'(ex_ready), 1);
    end
    dmem_ack = 0;
    do_op(0, 0, 3'b000, 32'h12345678, 0, 5, 1, 0, 0);
    check("alu_lit", wb_data, 32'h12345678);
    do_op(0, 1, 3'b000, 32'h103, 32'hAB, 7, 1, 2, 0);
    check("sb_hold", wb_data, 32'h12345678);
    do_op(1, 0, 3'b000, 32'h101, 0, 9, 1, 1, 32'h00008000);
    check("lb_lit", wb_data, 32'hFFFFFF80);
    do_op(1, 0, 3'b100, 32'h101, 0, 9, 1, 0, 32'h00008000);
    check("lbu_lit", wb_data, 32'h00000080);
    do_op(1, 0, 3'b001, 32'h202, 0, 3, 1, 0, 32'hBEEF0000);
    check("lh_lit", wb_data, 32'hFFFFBEEF);
    do_op(1, 0, 3'b010, 32'h102, 0, 4, 1, 1, 32'hCAFEF00D);
`ifndef MISALIGN_TRAP_EN
    check("lw_mis_lit", wb_data, 32'hCAFEF00D);
`endif
    ex_valid = 1; ex_MemRead = 1; ex_MemWrite = 0; ex_funct3 = 3'b010;
    ex_ALU_result = 32'h300; ex_rd = 6; ex_RegWrite = 1;
    tick;
    ex_valid = 0;
    tick;
    check("rst_acc_req", 32'(dmem_req), 1);
    reset = 1;
    tick;
    reset = 0;
    check("rst_acc_abandon", 32'(dmem_req), 0);
    check("rst_acc_ready", 32'(ex_ready), 1);
    check("rst_acc_wb", 32'(wb_valid), 0);
    dmem_ack = 1;
    tick;
    dmem_ack = 0;
    check("rst_acc_nowb", 32'(wb_valid), 0);
    exp_data = 0;
    known = 1;
    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(0, 2);
      if (k == 0)
        do_op(0, 0, 3'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom), 0, 0);
      else if (k == 1)
        do_op(0, 1, f3s[$urandom_range(0, 2)], $urandom, $urandom, 5'($urandom), 1'($urandom),
              $urandom_range(0, 4), $urandom);
      else
        do_op(1, 0, f3s[$urandom_range(0, 4)], $urandom, $urandom, 5'($urandom), 1'($urandom),
              $urandom_range(0, 4), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        tick;
        check("gap_valid", 32'(wb_valid), 0);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have ex_valid, input, 1: execute-stage result present this cycle.
REQ-004 SHALL have ex_ready, output, 1: stage accepts ex_* this cycle.
REQ-005 SHALL have ex_ALU_result, input, 32: result or effective address.
REQ-006 SHALL have ex_store_data, input, 32: rs2 value for stores.
REQ-007 SHALL have the following 1-bit inputs: ex_MemRead, ex_MemWrite, ex_RegWrite.
REQ-008 SHALL have ex_funct3, input, 3 (access size/sign), and ex_rd, input, 5.
REQ-009 SHALL have dmem_req, dmem_we, output, 1 each, and dmem_addr, output, 32, word-aligned (bits [1:0]=0).
REQ-010 SHALL have dmem_wdata, output, 32, and dmem_wstrb, output, 4 (byte-lane enables).
REQ-011 SHALL have dmem_ack, input, 1, and dmem_rdata, input, 32 (valid when ack=1).
REQ-012 SHALL have outputs wb_valid (1), wb_RegWrite (1), wb_rd (5), wb_data (32).

Function
REQ-013 SHALL implement FSM states IDLE and ACCESS; ex_ready=1 only in IDLE.
REQ-014 In IDLE, with ex_valid=1 and neither MemRead nor MemWrite, SHALL register wb_data=ex_ALU_result, rd and RegWrite, with wb_valid=1 the next cycle (latency 1) and state staying IDLE.
REQ-015 In IDLE, with ex_valid=1 and MemRead or MemWrite, SHALL latch the operands and enter ACCESS the next cycle.
REQ-016 In ACCESS, SHALL hold dmem_req=1 and all dmem_* outputs stable until dmem_ack=1, including when ack arrives in the first ACCESS cycle.
REQ-017 On the ack cycle, SHALL return to IDLE and assert wb_valid=1 the following cycle, for one cycle.
REQ-018 wb_valid SHALL be a 1-cycle pulse per accepted instruction; wb_* SHALL hold their last value when wb_valid=0.
REQ-019 Store lanes use addr[1:0]: SB (000) sets wstrb=1<<addr[1:0] with data replicated to all lanes; SH (001) sets wstrb=0011 or 1100 by addr[1]; SW (010) sets wstrb=1111.
REQ-020 Loads SHALL select the lane by addr[1:0]: LB 000 and LH 001 sign-extend; LBU 100 and LHU 101 zero-extend; LW 010 is passed through.
REQ-021 Stores SHALL produce wb_valid=1 with wb_RegWrite=0; loads SHALL place the extended data on wb_data.
REQ-022 ex_valid=0 in IDLE SHALL produce no state change and wb_valid=0.
REQ-023 ex_* inputs SHALL be ignored while in ACCESS.
REQ-024 dmem_ack outside ACCESS SHALL be ignored.

Reset
REQ-025 Reset SHALL force state=IDLE and set dmem_req, dmem_we, dmem_wstrb, wb_valid, wb_RegWrite, wb_rd and wb_data to 0; dmem_addr and dmem_wdata SHALL be set to 0.
REQ-026 Reset asserted during ACCESS SHALL abandon the access: dmem_req=0 the cycle after reset is sampled, and no wb_valid is produced.

Configuration
REQ-027 Macro MISALIGN_TRAP_EN defined: SHALL add output wb_misaligned (1). A halfword access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL skip ACCESS and produce wb_valid=1 the next cycle with wb_misaligned=1, wb_RegWrite=0 and no dmem_req.
REQ-028 Macro undefined: SHALL have no wb_misaligned port; a misaligned access SHALL be performed with addr[0] forced to 0 (half) or addr[1:0] forced to 0 (word).

Verification
REQ-029 ALU op: ALU_result=0x12345678, rd=5, RegWrite=1 -> next cycle wb_valid=1, wb_data=0x12345678, wb_rd=5, no dmem_req.
REQ-030 SB: addr=0x103, data=0xAB -> dmem_addr=0x100, wstrb=1000, wdata=0xABABABAB, we=1; ack after 3 cycles -> dmem_req held 3 cycles, then wb_valid with RegWrite=0.
REQ-031 LB: addr=0x101, rdata=0x0000_8000 -> wb_data=0xFFFFFF80; LBU with the same inputs -> wb_data=0x00000080.
REQ-032 LH: addr=0x202, rdata=0xBEEF_0000, ack in the first ACCESS cycle -> wb_data=0xFFFFBEEF two cycles after acceptance.
REQ-033 Reset pulsed in the 2nd ACCESS cycle with no ack -> dmem_req=0 next cycle, ex_ready=1, no wb_valid.
REQ-034 LW at 0x102: with MISALIGN_TRAP_EN -> wb_misaligned=1 and no dmem_req; without it -> dmem_addr=0x100 and a normal load.
